// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register as a 2-entry skid buffer; resolves BEQ/BNE at capture. Optional EX_MEM_FWD_EN adds forwarding taps.
// Latency: one cycle into an empty buffer; otherwise the entry appears when it reaches the head slot.
// Backpressure: o_ready comes from the registered occupancy only, so one stalled cycle is absorbed with no i_ready->o_ready path.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic              i_zflag,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [4:0]        i_ctrl,
    input  logic              i_beq,
    input  logic              i_bne,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_alu_res,
    output logic [DATA_W-1:0] o_store_data,
    output logic [REG_AW-1:0] o_rd,
    output logic [4:0]        o_ctrl,
    output logic              o_br_taken
`ifdef EX_MEM_FWD_EN
    ,
    output logic              o_fwd_valid,
    output logic [REG_AW-1:0] o_fwd_rd,
    output logic [DATA_W-1:0] o_fwd_data
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd;
        logic [4:0]        ctrl;
        logic              br_taken;
    } entry_t;

    cnt_t   cnt_q, cnt_d;
    entry_t slot0_q, slot0_d;   // slot0 is always the head
    entry_t slot1_q, slot1_d;
    entry_t in_ent;
    logic   push, pop;

    always_comb begin
        in_ent            = '0;
        in_ent.alu_res    = i_alu_res;
        in_ent.store_data = i_store_data;
        in_ent.rd         = i_rd;
        in_ent.ctrl       = i_ctrl;
        in_ent.br_taken   = (i_beq & ~i_zflag) | (i_bne & i_zflag);
    end

    assign o_ready = (cnt_q != FULL);
    assign o_valid = (cnt_q != EMPTY);
    assign push    = i_valid & o_ready & ~i_flush;
    assign pop     = o_valid & i_ready;

    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (i_flush) begin
            cnt_d = EMPTY;
        end else begin
            case (cnt_q)
                EMPTY: if (push) begin
                    slot0_d = in_ent;
                    cnt_d   = ONE;
                end
                ONE: begin
                    if (push && pop) begin
                        slot0_d = in_ent;
                    end else if (push) begin
                        slot1_d = in_ent;
                        cnt_d   = FULL;
                    end else if (pop) begin
                        cnt_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    slot0_d = slot1_q;
                    cnt_d   = ONE;
                end
                default: cnt_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign o_alu_res    = slot0_q.alu_res;
    assign o_store_data = slot0_q.store_data;
    assign o_rd         = slot0_q.rd;
    assign o_ctrl       = slot0_q.ctrl;
    assign o_br_taken   = slot0_q.br_taken;

`ifdef EX_MEM_FWD_EN
    // ctrl[4] = reg_write, ctrl[3] = mem_read; loads are not forwardable from here
    assign o_fwd_valid = o_valid & slot0_q.ctrl[4] & ~slot0_q.ctrl[3] & (slot0_q.rd != '0);
    assign o_fwd_rd    = slot0_q.rd;
    assign o_fwd_data  = slot0_q.alu_res;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a queue-based reference model.
module tb_ex_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_alu_res;
    logic        i_zflag;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd;
    logic [4:0]  i_ctrl;
    logic        i_beq;
    logic        i_bne;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_alu_res;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd;
    logic [4:0]  o_ctrl;
    logic        o_br_taken;
`ifdef EX_MEM_FWD_EN
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_rd;
    logic [31:0] o_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
        logic        br;
    } ent_t;
    ent_t q[$];

    ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_res(i_alu_res), .i_zflag(i_zflag), .i_store_data(i_store_data),
        .i_rd(i_rd), .i_ctrl(i_ctrl), .i_beq(i_beq), .i_bne(i_bne), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_res(o_alu_res),
        .o_store_data(o_store_data), .o_rd(o_rd), .o_ctrl(o_ctrl), .o_br_taken(o_br_taken)
`ifdef EX_MEM_FWD_EN
        , .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two entries; flush empties it and drops input.
    task automatic model_update();
        ent_t e;
        bit   pu, po;
        pu = i_valid && (q.size() < 2) && !i_flush;
        po = (q.size() > 0) && i_ready;
        e.alu  = i_alu_res;
        e.sd   = i_store_data;
        e.rd   = i_rd;
        e.ctrl = i_ctrl;
        e.br   = (i_beq && !i_zflag) || (i_bne && i_zflag);
        if (i_flush) begin
            q.delete();
        end else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        check("o_valid", 64'(o_valid), 64'(q.size() != 0));
        check("o_ready", 64'(o_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            check("o_alu_res", 64'(o_alu_res), 64'(q[0].alu));
            check("o_store_data", 64'(o_store_data), 64'(q[0].sd));
            check("o_rd", 64'(o_rd), 64'(q[0].rd));
            check("o_ctrl", 64'(o_ctrl), 64'(q[0].ctrl));
            check("o_br_taken", 64'(o_br_taken), 64'(q[0].br));
`ifdef EX_MEM_FWD_EN
            check("o_fwd_valid", 64'(o_fwd_valid),
                  64'(q[0].ctrl[4] && !q[0].ctrl[3] && q[0].rd != 5'd0));
            check("o_fwd_rd", 64'(o_fwd_rd), 64'(q[0].rd));
            check("o_fwd_data", 64'(o_fwd_data), 64'(q[0].alu));
`endif
        end
    endtask

    // Inputs are set at the falling edge, sampled at the rising edge, checked at the next falling edge.
    task automatic tick();
        @(posedge i_clk);
        model_update();
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic idle();
        i_valid = 0; i_alu_res = 0; i_zflag = 0; i_store_data = 0; i_rd = 0;
        i_ctrl = 0; i_beq = 0; i_bne = 0; i_flush = 0; i_ready = 1;
    endtask

    task automatic push_val(input logic [31:0] alu, input logic rdy);
        i_valid = 1; i_alu_res = alu; i_store_data = ~alu; i_rd = alu[4:0];
        i_ctrl = 5'b10000; i_beq = 0; i_bne = 0; i_zflag = 1; i_ready = rdy;
        tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'(0));
        check({tag, "_alu"}, 64'(o_alu_res), 64'(0));
        check({tag, "_sd"}, 64'(o_store_data), 64'(0));
        check({tag, "_rd"}, 64'(o_rd), 64'(0));
        check({tag, "_ctrl"}, 64'(o_ctrl), 64'(0));
        check({tag, "_br"}, 64'(o_br_taken), 64'(0));
    endtask

    initial begin
        idle();
        i_rst_n = 0;
        #2;
        check_zero_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1;
        #1;
        check("reset_ready", 64'(o_ready), 64'(1));
        @(negedge i_clk);

        // First instruction and a steady stream
        i_valid = 1; i_alu_res = 32'h10; i_rd = 5'd8; i_ctrl = 5'b10000; i_ready = 1;
        tick();
        check("first_valid", 64'(o_valid), 64'(1));
        check("first_alu", 64'(o_alu_res), 64'(32'h10));
        check("first_rd", 64'(o_rd), 64'(8));
        for (int k = 1; k <= 4; k++) begin
            push_val(32'h10 + 32'(k), 1);
            check("stream_alu", 64'(o_alu_res), 64'(32'h10 + 32'(k)));
        end
        idle(); tick();
        check("drained", 64'(o_valid), 64'(0));

        // Stall fills the skid slot, then drains in order
        push_val(32'hA, 0);
        push_val(32'hB, 0);
        check("full_ready", 64'(o_ready), 64'(0));
        check("full_head", 64'(o_alu_res), 64'(32'hA));
        idle(); i_ready = 0; tick(); tick();
        check("hold_head", 64'(o_alu_res), 64'(32'hA));
        i_ready = 1; tick();
        check("drain_b", 64'(o_alu_res), 64'(32'hB));
        check("drain_ready", 64'(o_ready), 64'(1));
        tick();
        check("drain_empty", 64'(o_valid), 64'(0));

        // Branch resolution: {beq, bne, zflag, expected}
        begin
            logic [3:0] br_tab [5];
            logic [3:0] row;
            br_tab = '{4'b1001, 4'b1010, 4'b0111, 4'b0100, 4'b0000};
            foreach (br_tab[n]) begin
                row = br_tab[n];
                idle(); i_valid = 1; i_alu_res = 32'(n);
                i_beq = row[3]; i_bne = row[2]; i_zflag = row[1];
                tick();
                check("br_taken", 64'(o_br_taken), 64'(row[0]));
            end
            idle(); tick();
        end

        // Flush from FULL drops everything including the concurrent push
        push_val(32'h21, 0);
        push_val(32'h22, 0);
        i_valid = 1; i_alu_res = 32'h23; i_flush = 1; i_ready = 0;
        tick();
        check("flush_valid", 64'(o_valid), 64'(0));
        check("flush_ready", 64'(o_ready), 64'(1));
        idle(); tick();
        check("flush_stays_empty", 64'(o_valid), 64'(0));

        // Asynchronous reset while FULL
        push_val(32'h31, 0);
        push_val(32'h32, 0);
        idle(); i_ready = 0;
        #2;
        i_rst_n = 0;
        #1;
        check_zero_outputs("areset");
        q.delete();
        @(negedge i_clk);
        i_rst_n = 1;
        #1;
        check("areset_ready", 64'(o_ready), 64'(1));
        check("areset_valid", 64'(o_valid), 64'(0));
        @(negedge i_clk);

`ifdef EX_MEM_FWD_EN
        idle(); i_valid = 1; i_alu_res = 32'h55; i_rd = 5'd0; i_ctrl = 5'b10000; tick();
        check("fwd_rd0", 64'(o_fwd_valid), 64'(0));
        i_rd = 5'd9; i_ctrl = 5'b11010; tick();
        check("fwd_load", 64'(o_fwd_valid), 64'(0));
        i_alu_res = 32'h66; i_ctrl = 5'b10000; tick();
        check("fwd_ok", 64'(o_fwd_valid), 64'(1));
        check("fwd_data", 64'(o_fwd_data), 64'(32'h66));
        idle(); tick();
`endif

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            i_valid      = ($urandom_range(0, 9) < 7);
            i_alu_res    = $urandom;
            i_store_data = $urandom;
            i_rd         = 5'($urandom_range(0, 31));
            i_ctrl       = 5'($urandom_range(0, 31));
            i_zflag      = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1:    begin i_beq = 1; i_bne = 0; end
                2, 3:    begin i_beq = 0; i_bne = 1; end
                4:       begin i_beq = 1; i_bne = 1; end
                default: begin i_beq = 0; i_bne = 0; end
            endcase
            i_ready = ($urandom_range(0, 9) < 6);
            i_flush = ($urandom_range(0, 99) < 4);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage between the execute-stage ALU and the data-memory stage of the MIPS datapath.
- Captures the ALU result, ALU zero-flag, destination register, store data and memory/writeback control bits.
- Resolves the BEQ/BNE branch decision from the ALU flag.
- Implemented as a 2-entry skid buffer with valid/ready handshakes on both sides, so the stage sustains one instruction per cycle while absorbing one cycle of downstream stall.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_AW, 5, width of register-file address.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  EX stage presents a valid instruction.
- o_ready  output  1  stage can accept an instruction this cycle.
- i_alu_res  input  DATA_W  ALU result.
- i_zflag  input  1  ALU flag: 1 when ALU result is nonzero, 0 when result is zero.
- i_store_data  input  DATA_W  rt value for SW.
- i_rd  input  REG_AW  destination register.
- i_ctrl  input  5  {reg_write, mem_read, mem_write, mem_to_reg, is_store_word}.
- i_beq  input  1  instruction is BEQ.
- i_bne  input  1  instruction is BNE.
- i_flush  input  1  discard all held and incoming instructions.
- o_valid  output  1  head entry valid toward MEM stage.
- i_ready  input  1  MEM stage accepts head entry.
- o_alu_res  output  DATA_W  head ALU result (memory address or writeback value).
- o_store_data  output  DATA_W  head store data.
- o_rd  output  REG_AW  head destination register.
- o_ctrl  output  5  head control bits.
- o_br_taken  output  1  head is a taken branch; meaningful only when o_valid=1.

Behaviour:
- Storage: two entry slots plus a 2-bit occupancy count (states EMPTY=0, ONE=1, FULL=2), FIFO order.
- o_ready = (count != FULL), driven from registered count, with no combinational path from i_ready.
- push = i_valid & o_ready & ~i_flush.
- pop = o_valid & i_ready.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE with the new entry as head.
  - FULL: pop -> ONE; otherwise hold.
- i_flush: count -> EMPTY on the next edge regardless of push/pop. Concurrent input is dropped. Flush has priority over all other events.
- o_valid = (count != EMPTY). Output fields always reflect the head slot.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N when the buffer was EMPTY, or after it reaches the head otherwise.
- Branch resolution at capture:
  - br_taken = (i_beq & ~i_zflag) | (i_bne & i_zflag), stored per entry.
  - i_beq and i_bne both 1 is illegal; the result is then the OR of both terms.
- Held entries never change while waiting. A full buffer with i_ready=0 holds indefinitely, with outputs stable.
- Reset (i_rst_n=0, asynchronous):
  - count=EMPTY.
  - All slot fields = 0.
  - o_valid=0, o_ready=1 once reset deasserts, o_alu_res=0, o_store_data=0, o_rd=0, o_ctrl=0, o_br_taken=0.
- Reset mid-transfer discards all entries; no partial state survives.
- Entries with i_rd=0 are carried unchanged. Suppressing writes to $zero is the writeback stage's responsibility.

Optional Feature:
- Macro EX_MEM_FWD_EN.
- When defined, adds outputs:
  - o_fwd_valid (1): = o_valid & o_ctrl[reg_write] & ~o_ctrl[mem_read] & (o_rd != 0).
  - o_fwd_rd (REG_AW): = o_rd.
  - o_fwd_data (DATA_W): = o_alu_res.
- These give the EX-stage forwarding mux access to the head result.
- When not defined, these ports do not exist and no forwarding logic is synthesized.

Test Plan:
- Reset, then i_valid=1 with alu_res=0x00000010, rd=8, ctrl=reg_write, i_ready=1 -> next cycle o_valid=1, o_alu_res=0x10, o_rd=8; steady stream gives one output per cycle.
- i_ready=0; push 0xA then 0xB -> o_ready=0 after the second push, o_alu_res=0xA held; raise i_ready -> 0xA then 0xB delivered in order, o_ready=1 again.
- BEQ with i_zflag=0 -> o_br_taken=1. BEQ with i_zflag=1 -> 0. BNE with i_zflag=1 -> 1. Non-branch -> 0.
- FULL state with i_flush=1 and i_valid=1 -> next cycle o_valid=0, count EMPTY, incoming entry not captured.
- Assert i_rst_n=0 asynchronously mid-stream while FULL -> outputs zero immediately without a clock edge; after release o_ready=1, o_valid=0.
- With EX_MEM_FWD_EN: head rd=0 with reg_write -> o_fwd_valid=0. Head rd=9 with mem_read -> o_fwd_valid=0. Head rd=9 with reg_write only -> o_fwd_valid=1 and o_fwd_data equals o_alu_res.
